// File: rtl/pwm_pkg.sv
// Shared definitions for the pwm family: the dead-time FSM state encoding and the default counter width.
// Used by pwm_deadtime, with or without PWM_DEADTIME_POLARITY_EN.
package pwm_pkg;

  localparam int DT_WIDTH_DEF = 16;

  typedef enum logic [2:0] {
    OFF   = 3'd0,
    DT_HI = 3'd1,
    HI_ON = 3'd2,
    DT_LO = 3'd3,
    LO_ON = 3'd4
  } dt_state_e;

endpackage

// File: rtl/pwm_deadtime_if.sv
// Signal bundle between the pwm source and the dead-time stage.
// PWM_DEADTIME_POLARITY_EN adds the hi_pol/lo_pol gate polarity inputs.
interface pwm_deadtime_if
  import pwm_pkg::*;
#(
  parameter int DT_WIDTH = DT_WIDTH_DEF
);
  logic                en;
  logic                pwm_in;
  logic [DT_WIDTH-1:0] dead_rise;
  logic [DT_WIDTH-1:0] dead_fall;
`ifdef PWM_DEADTIME_POLARITY_EN
  logic                hi_pol;
  logic                lo_pol;
`endif
  logic                hi_out;
  logic                lo_out;
  logic                dt_active;
  dt_state_e           state;

  // No valid/ready handshake here: every input is a level sampled on each clk edge,
  // and every output is a level updated on each clk edge; state is debug visibility only.
`ifdef PWM_DEADTIME_POLARITY_EN
  modport master (
    output en, pwm_in, dead_rise, dead_fall, hi_pol, lo_pol,
    input  hi_out, lo_out, dt_active, state
  );
  modport slave (
    input  en, pwm_in, dead_rise, dead_fall, hi_pol, lo_pol,
    output hi_out, lo_out, dt_active, state
  );
`else
  modport master (
    output en, pwm_in, dead_rise, dead_fall,
    input  hi_out, lo_out, dt_active, state
  );
  modport slave (
    input  en, pwm_in, dead_rise, dead_fall,
    output hi_out, lo_out, dt_active, state
  );
`endif
endinterface

// File: rtl/pwm_dt_counter.sv
// Loadable down-counter timing the dead band; saturates at zero instead of wrapping.
module pwm_dt_counter #(
  parameter int DT_WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                load,
  input  logic [DT_WIDTH-1:0] load_val,
  output logic                zero
);

  logic [DT_WIDTH-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - DT_WIDTH'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/pwm_deadtime.sv
// Complementary gate pair with a programmable dead band on every pwm_in edge.
// PWM_DEADTIME_POLARITY_EN adds per-gate polarity (XNOR after state decode).
module pwm_deadtime
  import pwm_pkg::*;
#(
  parameter int DT_WIDTH = DT_WIDTH_DEF
) (
  input logic            clk,
  input logic            rst_n,
  pwm_deadtime_if.slave  bus
);

  dt_state_e           state;
  logic                go_hi;
  logic                go_lo;
  logic                cnt_load;
  logic                cnt_zero;
  logic [DT_WIDTH-1:0] cnt_load_val;

  // An edge request is any moment the wanted gate differs from the one being driven or timed.
  always_comb begin
    go_hi = 1'b0;
    go_lo = 1'b0;
    if (bus.en) begin
      unique case (state)
        OFF:          begin go_hi = bus.pwm_in; go_lo = !bus.pwm_in; end
        LO_ON, DT_LO: go_hi = bus.pwm_in;
        HI_ON, DT_HI: go_lo = !bus.pwm_in;
        default:      ;
      endcase
    end
  end

  always_comb begin
    cnt_load     = (go_hi && bus.dead_rise != '0) || (go_lo && bus.dead_fall != '0);
    cnt_load_val = go_hi ? bus.dead_rise - DT_WIDTH'(1) : bus.dead_fall - DT_WIDTH'(1);
  end

  pwm_dt_counter #(.DT_WIDTH(DT_WIDTH)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (!bus.en),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= OFF;
    end else if (!bus.en) begin
      state <= OFF;
    end else if (go_hi) begin
      state <= (bus.dead_rise == '0) ? HI_ON : DT_HI;
    end else if (go_lo) begin
      state <= (bus.dead_fall == '0) ? LO_ON : DT_LO;
    end else begin
      unique case (state)
        DT_HI:   if (cnt_zero) state <= HI_ON;
        DT_LO:   if (cnt_zero) state <= LO_ON;
        default: ;
      endcase
    end
  end

  // Outputs decode the state flop alone, so both gates can never be on together.
  logic hi_dec;
  logic lo_dec;
  assign hi_dec = (state == HI_ON);
  assign lo_dec = (state == LO_ON);

`ifdef PWM_DEADTIME_POLARITY_EN
  assign bus.hi_out = hi_dec ~^ bus.hi_pol;
  assign bus.lo_out = lo_dec ~^ bus.lo_pol;
`else
  assign bus.hi_out = hi_dec;
  assign bus.lo_out = lo_dec;
`endif
  assign bus.dt_active = (state == DT_HI) || (state == DT_LO);
  assign bus.state     = state;

endmodule

// File: tb/tb_pwm_deadtime.sv
// Self-checking bench for pwm_deadtime: directed scenarios plus random pwm/en/dead-value traffic
// against a timestamp-based reference model.
module tb_pwm_deadtime;
  import pwm_pkg::*;

  localparam int W = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pwm_deadtime_if #(.DT_WIDTH(W)) bus ();

  pwm_deadtime #(.DT_WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- reference model ----------------
  // The committed gate direction, the cycle its request was made and the dead value captured
  // then; the gate is on once the current cycle is at least request + dead.
  int   checks = 0;
  int   errors = 0;
  longint cyc = 0;
  bit   m_off = 1'b1;
  bit   m_dir = 1'b0;
  longint m_treq = 0;
  longint m_d = 0;
  logic [2:0] exp_q[$];

  task automatic model_edge();
    logic e_hi, e_lo, e_dt;
    cyc++;
    if (!bus.en) begin
      m_off = 1'b1;
    end else if (m_off || (bus.pwm_in != m_dir)) begin
      m_off  = 1'b0;
      m_dir  = bus.pwm_in;
      m_treq = cyc;
      m_d    = bus.pwm_in ? longint'(bus.dead_rise) : longint'(bus.dead_fall);
    end
    e_hi = !m_off && m_dir && (cyc >= m_treq + m_d);
    e_lo = !m_off && !m_dir && (cyc >= m_treq + m_d);
    e_dt = !m_off && (cyc < m_treq + m_d);
    exp_q.push_back({e_hi, e_lo, e_dt});
  endtask

  // ---------------- scoreboard ----------------
  task automatic check_out(input string tag);
    logic [2:0] e;
    logic [2:0] o;
    o = {bus.hi_out, bus.lo_out, bus.dt_active};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: observed %b expected <queue empty>", tag, o);
      return;
    end
    e = exp_q.pop_front();
    assert (o === e) else begin
      errors++;
      $error("FAIL %s cyc=%0d: observed hi/lo/dt=%b expected %b", tag, cyc, o, e);
    end
    checks++;
    assert ((bus.hi_out & bus.lo_out) === 1'b0) else begin
      errors++;
      $error("FAIL %s overlap cyc=%0d: observed hi=%b lo=%b expected never both", tag, cyc,
             bus.hi_out, bus.lo_out);
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_out(tag);
  endtask

  task automatic check_val(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    bit hi_seen;
    bus.en        = 1'b0;
    bus.pwm_in    = 1'b0;
    bus.dead_rise = '0;
    bus.dead_fall = '0;
`ifdef PWM_DEADTIME_POLARITY_EN
    bus.hi_pol = 1'b1;
    bus.lo_pol = 1'b1;
`endif
    #1;
    check_val("reset_hi", bus.hi_out, 0);
    check_val("reset_lo", bus.lo_out, 0);
    check_val("reset_dt", bus.dt_active, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reach HI_ON, then pull reset asynchronously in mid-cycle.
    bus.en = 1'b1; bus.pwm_in = 1'b1; bus.dead_rise = 16'd2; bus.dead_fall = 16'd3;
    repeat (5) step("to_hi_on");
    check_val("pre_reset_hi", bus.hi_out, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("async_reset_hi", bus.hi_out, 0);
    check_val("async_reset_lo", bus.lo_out, 0);
    check_val("async_reset_dt", bus.dt_active, 0);
    m_off = 1'b1;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    bus.pwm_in = 1'b0;
    repeat (6) step("release_lo");

    // Nominal 20-cycle, 50% pwm with asymmetric dead bands.
    bus.dead_rise = 16'd4; bus.dead_fall = 16'd2;
    for (int i = 0; i < 60; i++) begin
      bus.pwm_in = ((i % 20) < 10);
      step("nominal");
    end

    // Zero dead time: gates follow pwm_in one cycle late with no gap.
    bus.dead_rise = '0; bus.dead_fall = '0;
    for (int i = 0; i < 40; i++) begin
      bus.pwm_in = 1'($urandom_range(0, 1));
      step("zero_dt");
    end

    // Abort: rise band longer than the pwm pulse, hi must never assert.
    bus.dead_rise = 16'd10; bus.dead_fall = 16'd3;
    bus.pwm_in = 1'b0;
    repeat (6) step("abort_pre");
    hi_seen = 1'b0;
    bus.pwm_in = 1'b1;
    repeat (3) begin step("abort_pulse"); hi_seen |= bus.hi_out; end
    bus.pwm_in = 1'b0;
    repeat (8) begin step("abort_post"); hi_seen |= bus.hi_out; end
    check_val("abort_hi_never", hi_seen, 0);
    check_val("abort_lo_back", bus.lo_out, 1);

    // Disable in the middle of a rise band, then re-enable.
    bus.dead_rise = 16'd5;
    bus.pwm_in = 1'b1;
    repeat (2) step("dis_band");
    bus.en = 1'b0;
    step("dis_off");
    bus.en = 1'b1;
    repeat (8) step("dis_reen");

    // Random traffic with en drops and dead values changing mid-band.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 5) == 0) bus.pwm_in = ~bus.pwm_in;
      if ($urandom_range(0, 7) == 0) bus.dead_rise = W'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) bus.dead_fall = W'($urandom_range(0, 7));
      bus.en = ($urandom_range(0, 49) != 0);
      step("random");
    end

    // Maximum dead value: rise exactly 65535 edges after the lo drop.
    bus.en = 1'b1; bus.pwm_in = 1'b0; bus.dead_fall = 16'd1;
    repeat (4) step("max_pre");
    bus.dead_rise = 16'hFFFF;
    bus.pwm_in = 1'b1;
    step("max_drop");
    check_val("max_lo_dropped", bus.lo_out, 0);
    n = 0;
    while (!bus.hi_out && n < 70000) begin
      step("max_band");
      n++;
    end
    check_val("max_rise_delay", n, 65535);

`ifdef PWM_DEADTIME_POLARITY_EN
    bus.hi_pol = 1'b0;
    rst_n = 1'b0;
    #1;
    check_val("pol_reset_hi_idle", bus.hi_out, 1);
    check_val("pol_reset_lo_idle", bus.lo_out, 0);
`endif

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
